// File: rtl/uart_sim_pkg.sv
// Shared definitions for the UART simulation helpers (input responder and,
// later, the output monitor).
package uart_sim_pkg;

    // Responder state: READY serves reads, GAP enforces idle cycles after a serve.
    typedef enum logic {
        READY = 1'b0,
        GAP   = 1'b1
    } resp_state_t;

    // Character handed back whenever nothing is actually served.
    localparam logic [7:0] EMPTY_CH_DEFAULT = 8'hff;

endpackage

// File: rtl/uart_in_responder_if.sv
// Host-side push channel and DUT-side read channel of the UART input responder.
//
// Handshake semantics:
//   host push : a character moves when host_valid && host_ready at a rising clock
//               edge. host_ready depends on registered state only.
//   DUT read  : io_uart_in_valid is a request sampled at the rising edge; the
//               answer io_uart_in_ch is already valid during that same cycle and
//               depends on registered state only. There is no back-pressure on
//               reads: an unserved read simply sees the empty character.
interface uart_in_responder_if;
    logic       host_valid;
    logic [7:0] host_ch;
    logic       host_ready;
    logic       io_uart_in_valid;
    logic [7:0] io_uart_in_ch;

    // Driver side (host model and DUT-under-test read port)
    modport master (
        output host_valid,
        output host_ch,
        output io_uart_in_valid,
        input  host_ready,
        input  io_uart_in_ch
    );

    // Responder side
    modport slave (
        input  host_valid,
        input  host_ch,
        input  io_uart_in_valid,
        output host_ready,
        output io_uart_in_ch
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always presented on o_head;
// pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full/empty come from the registered occupancy, so they never see this cycle's requests.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; it is only observable through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop balance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uart_in_responder.sv
// Feeds host-supplied characters to a simulated DUT's UART input port. The DUT
// reads with io_uart_in_valid and sees the answer in the same cycle; after each
// served character an optional MIN_GAP idle window returns EMPTY_CH.
module uart_in_responder
    import uart_sim_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] EMPTY_CH = EMPTY_CH_DEFAULT,
    parameter int         MIN_GAP  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_in_responder_if.slave     bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            served_cnt,
    output logic [31:0]            underrun_cnt,
    output resp_state_t            o_state
);
    // Gap counter holds MIN_GAP-1 at most; keep at least one bit so it always exists.
    localparam int GW       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int GAP_LOAD = (MIN_GAP > 0) ? (MIN_GAP - 1) : 0;

    resp_state_t r_state;
    resp_state_t w_state_nxt;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] w_gap_nxt;
    logic [31:0]   r_served;
    logic [31:0]   r_underrun;

    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_underrun;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (bus.host_valid),
        .i_push_data (bus.host_ch),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

    // Serve only in READY with data; an empty READY read is an underrun, a GAP read is neither.
    assign w_pop      = bus.io_uart_in_valid && (r_state == READY) && !w_empty;
    assign w_underrun = bus.io_uart_in_valid && (r_state == READY) && w_empty;

    assign bus.host_ready    = !w_full;
    assign bus.io_uart_in_ch = ((r_state == READY) && !w_empty) ? w_head : EMPTY_CH;
    assign served_cnt        = r_served;
    assign underrun_cnt      = r_underrun;
    assign o_state           = r_state;

    // State and gap counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= READY;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Next state: a serve opens the gap window, which counts down to zero then releases.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        case (r_state)
            READY: begin
                if (w_pop && (MIN_GAP > 0)) begin
                    w_state_nxt = GAP;
                    w_gap_nxt   = GW'(GAP_LOAD);
                end
            end
            GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = READY;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            default: begin
                w_state_nxt = READY;
                w_gap_nxt   = '0;
            end
        endcase
    end

    // Statistics counters; both wrap silently at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_served   <= '0;
            r_underrun <= '0;
        end else begin
            if (w_pop) begin
                r_served <= r_served + 32'd1;
            end
            if (w_underrun) begin
                r_underrun <= r_underrun + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_in_responder.sv
// Bench for uart_in_responder: one instance with MIN_GAP=0 and one with MIN_GAP=2,
// sharing clock and reset. Expected characters travel through exp_q.
module tb_uart_in_responder;
    import uart_sim_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_in_responder_if if0 ();
    uart_in_responder_if if2 ();

    logic [4:0]  cnt0;
    logic [4:0]  cnt2;
    logic [31:0] served0;
    logic [31:0] served2;
    logic [31:0] under0;
    logic [31:0] under2;
    resp_state_t st0;
    resp_state_t st2;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_served0 = 0;
    int exp_under0  = 0;

    uart_in_responder #(.DEPTH(16), .EMPTY_CH(8'hff), .MIN_GAP(0)) dut0 (
        .clock(clk), .reset(rst), .bus(if0.slave),
        .fifo_count(cnt0), .served_cnt(served0), .underrun_cnt(under0), .o_state(st0)
    );

    uart_in_responder #(.DEPTH(16), .EMPTY_CH(8'hff), .MIN_GAP(2)) dut2 (
        .clock(clk), .reset(rst), .bus(if2.slave),
        .fifo_count(cnt2), .served_cnt(served2), .underrun_cnt(under2), .o_state(st2)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        if0.host_valid = 0; if0.host_ch = 0; if0.io_uart_in_valid = 0;
        if2.host_valid = 0; if2.host_ch = 0; if2.io_uart_in_valid = 0;
        rst = 1'b1;
        #3;
        checks++; if (if0.host_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", if0.host_ready); end
        checks++; if (if0.io_uart_in_ch !== 8'hff) begin errors++; $display("FAIL rst_ch got=%h exp=ff", if0.io_uart_in_ch); end
        checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", cnt0); end
        checks++; if (served0 !== 32'd0 || under0 !== 32'd0) begin errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", served0, under0); end
        checks++; if (st0 !== READY) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", st0, READY); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_underrun;
        for (int i = 0; i < 3; i++) begin
            if0.io_uart_in_valid = 1;
            checks++; if (if0.io_uart_in_ch !== 8'hff) begin errors++; $display("FAIL underrun_ch[%0d] got=%h exp=ff", i, if0.io_uart_in_ch); end
            tick();
            exp_under0++;
        end
        if0.io_uart_in_valid = 0;
        checks++; if (under0 !== 32'(exp_under0)) begin errors++; $display("FAIL underrun_cnt got=%0d exp=%0d", under0, exp_under0); end
        checks++; if (served0 !== 32'(exp_served0)) begin errors++; $display("FAIL underrun_served got=%0d exp=%0d", served0, exp_served0); end
    endtask

    task automatic test_fifo_order;
        logic [7:0] chars [3];
        logic [7:0] exp;
        chars = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) begin
            if0.host_valid = 1; if0.host_ch = chars[i];
            checks++; if (if0.host_ready !== 1'b1) begin errors++; $display("FAIL order_ready[%0d] got=%b exp=1", i, if0.host_ready); end
            exp_q.push_back(chars[i]);
            tick();
        end
        if0.host_valid = 0;
        for (int i = 0; i < 3; i++) begin
            if0.io_uart_in_valid = 1;
            exp = exp_q.pop_front();
            checks++; if (if0.io_uart_in_ch !== exp) begin errors++; $display("FAIL order_ch[%0d] got=%h exp=%h", i, if0.io_uart_in_ch, exp); end
            tick();
            exp_served0++;
        end
        if0.io_uart_in_valid = 0;
        checks++; if (served0 !== 32'(exp_served0)) begin errors++; $display("FAIL order_served got=%0d exp=%0d", served0, exp_served0); end
        checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL order_count got=%0d exp=0", cnt0); end
    endtask

    task automatic test_full_wrap;
        logic [7:0] c;
        logic [7:0] exp;
        int n;
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom_range(0, 255));
            if0.host_valid = 1; if0.host_ch = c;
            checks++; if (if0.host_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, if0.host_ready); end
            exp_q.push_back(c);
            tick();
        end
        // 17th push attempt while full
        if0.host_ch = 8'h5a;
        checks++; if (if0.host_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", if0.host_ready); end
        checks++; if (cnt0 !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", cnt0); end
        tick();
        checks++; if (cnt0 !== 5'd16) begin errors++; $display("FAIL full_ignored got=%0d exp=16", cnt0); end
        // Push and read together while full: only the pop lands
        if0.host_ch = 8'hc3; if0.io_uart_in_valid = 1;
        exp = exp_q.pop_front();
        checks++; if (if0.io_uart_in_ch !== exp) begin errors++; $display("FAIL full_pop_ch got=%h exp=%h", if0.io_uart_in_ch, exp); end
        tick();
        exp_served0++;
        checks++; if (cnt0 !== 5'd15) begin errors++; $display("FAIL full_pop_count got=%0d exp=15", cnt0); end
        checks++; if (if0.host_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b exp=1", if0.host_ready); end
        // Streaming push/pop across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            c = 8'($urandom_range(0, 255));
            if0.host_valid = 1; if0.host_ch = c; if0.io_uart_in_valid = 1;
            exp = exp_q.pop_front();
            checks++; if (if0.io_uart_in_ch !== exp) begin errors++; $display("FAIL wrap_ch[%0d] got=%h exp=%h", i, if0.io_uart_in_ch, exp); end
            exp_q.push_back(c);
            tick();
            exp_served0++;
        end
        if0.host_valid = 0;
        checks++; if (cnt0 !== 5'd15) begin errors++; $display("FAIL wrap_count got=%0d exp=15", cnt0); end
        // Drain
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            exp = exp_q.pop_front();
            checks++; if (if0.io_uart_in_ch !== exp) begin errors++; $display("FAIL drain_ch[%0d] got=%h exp=%h", i, if0.io_uart_in_ch, exp); end
            tick();
            exp_served0++;
        end
        if0.io_uart_in_valid = 0;
        checks++; if (cnt0 !== 5'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", cnt0); end
        checks++; if (served0 !== 32'(exp_served0)) begin errors++; $display("FAIL drain_served got=%0d exp=%0d", served0, exp_served0); end
        checks++; if (under0 !== 32'(exp_under0)) begin errors++; $display("FAIL drain_underrun got=%0d exp=%0d", under0, exp_under0); end
    endtask

    task automatic test_simul_empty;
        logic [7:0] exp;
        if0.host_valid = 1; if0.host_ch = 8'h7a; if0.io_uart_in_valid = 1;
        exp_q.push_back(8'h7a);
        checks++; if (if0.io_uart_in_ch !== 8'hff) begin errors++; $display("FAIL simul_ch got=%h exp=ff", if0.io_uart_in_ch); end
        tick();
        exp_under0++;
        if0.host_valid = 0;
        checks++; if (under0 !== 32'(exp_under0)) begin errors++; $display("FAIL simul_underrun got=%0d exp=%0d", under0, exp_under0); end
        exp = exp_q.pop_front();
        checks++; if (if0.io_uart_in_ch !== exp) begin errors++; $display("FAIL simul_next_ch got=%h exp=%h", if0.io_uart_in_ch, exp); end
        tick();
        exp_served0++;
        if0.io_uart_in_valid = 0;
        checks++; if (served0 !== 32'(exp_served0)) begin errors++; $display("FAIL simul_served got=%0d exp=%0d", served0, exp_served0); end
        checks++; if (under0 !== 32'(exp_under0)) begin errors++; $display("FAIL simul_underrun2 got=%0d exp=%0d", under0, exp_under0); end
    endtask

    task automatic test_gap;
        logic [7:0] exp;
        if2.host_valid = 1; if2.host_ch = 8'h78; exp_q.push_back(8'h78); tick();
        if2.host_ch = 8'h79; exp_q.push_back(8'h79); tick();
        if2.host_valid = 0;
        if2.io_uart_in_valid = 1;
        exp = exp_q.pop_front();
        checks++; if (if2.io_uart_in_ch !== exp) begin errors++; $display("FAIL gap_first got=%h exp=%h", if2.io_uart_in_ch, exp); end
        tick();
        checks++; if (st2 !== GAP) begin errors++; $display("FAIL gap_state got=%0d exp=%0d", st2, GAP); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (if2.io_uart_in_ch !== 8'hff) begin errors++; $display("FAIL gap_idle[%0d] got=%h exp=ff", i, if2.io_uart_in_ch); end
            tick();
        end
        exp = exp_q.pop_front();
        checks++; if (if2.io_uart_in_ch !== exp) begin errors++; $display("FAIL gap_second got=%h exp=%h", if2.io_uart_in_ch, exp); end
        tick();
        if2.io_uart_in_valid = 0;
        checks++; if (under2 !== 32'd0) begin errors++; $display("FAIL gap_underrun got=%0d exp=0", under2); end
        checks++; if (served2 !== 32'd2) begin errors++; $display("FAIL gap_served got=%0d exp=2", served2); end
        repeat (3) tick();
        checks++; if (st2 !== READY) begin errors++; $display("FAIL gap_release got=%0d exp=%0d", st2, READY); end
    endtask

    task automatic test_reset_mid_gap;
        logic [7:0] c;
        logic [7:0] exp;
        for (int i = 0; i < 6; i++) begin
            c = 8'($urandom_range(0, 255));
            if2.host_valid = 1; if2.host_ch = c; exp_q.push_back(c);
            tick();
        end
        if2.host_valid = 0;
        if2.io_uart_in_valid = 1;
        exp = exp_q.pop_front();
        checks++; if (if2.io_uart_in_ch !== exp) begin errors++; $display("FAIL mid_serve got=%h exp=%h", if2.io_uart_in_ch, exp); end
        tick();
        if2.io_uart_in_valid = 0;
        checks++; if (cnt2 !== 5'd5 || st2 !== GAP) begin errors++; $display("FAIL mid_pre got=%0d/%0d exp=5/%0d", cnt2, st2, GAP); end
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        checks++; if (cnt2 !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", cnt2); end
        checks++; if (served2 !== 32'd0 || under2 !== 32'd0) begin errors++; $display("FAIL mid_counters got=%0d/%0d exp=0/0", served2, under2); end
        checks++; if (if2.io_uart_in_ch !== 8'hff) begin errors++; $display("FAIL mid_ch got=%h exp=ff", if2.io_uart_in_ch); end
        checks++; if (if2.host_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", if2.host_ready); end
        checks++; if (served0 !== 32'd0) begin errors++; $display("FAIL mid_served0 got=%0d exp=0", served0); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (st2 !== READY) begin errors++; $display("FAIL mid_state got=%0d exp=%0d", st2, READY); end
        checks++; if (if2.io_uart_in_ch !== 8'hff) begin errors++; $display("FAIL mid_after_ch got=%h exp=ff", if2.io_uart_in_ch); end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_fifo_order();
        test_full_wrap();
        test_simul_empty();
        test_gap();
        test_reset_mid_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_in_responder.md
UART_IN_RESPONDER -- requirements
Module: uart_in_responder

Interface
- REQ-001 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, minimum 2.
- REQ-002 SHALL have parameter EMPTY_CH, default 8'hff: character returned when nothing is served.
- REQ-003 SHALL have parameter MIN_GAP, default 0: idle cycles enforced after each served character.
- REQ-004 clock  input  1  single clock for all logic.
- REQ-005 reset  input  1  asynchronous, active-high reset.
- REQ-006 host_valid  input  1  host offers a character.
- REQ-007 host_ch  input  8  offered character.
- REQ-008 host_ready  output  1  host side may push; asserted while the FIFO is not full.
- REQ-009 io_uart_in_valid  input  1  DUT read request, sampled at posedge.
- REQ-010 io_uart_in_ch  output  8  character returned to the DUT.
- REQ-011 fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- REQ-012 served_cnt  output  32  number of characters delivered to the DUT.
- REQ-013 underrun_cnt  output  32  number of reads answered with EMPTY_CH while in READY state with the FIFO empty.

Function
- REQ-014 A push SHALL occur at a posedge when host_valid && host_ready.
- REQ-015 host_ready SHALL be !full, derived from registered state only, with no combinational path from io_uart_in_valid.
- REQ-016 The FIFO SHALL be show-ahead; io_uart_in_ch SHALL equal the head entry when state==READY && !empty, and EMPTY_CH otherwise.
- REQ-017 io_uart_in_ch SHALL be combinational from registered state only, so the DUT sees the value in the same cycle it requests.
- REQ-018 A pop SHALL occur at a posedge when io_uart_in_valid && state==READY && !empty; served_cnt SHALL increment by 1 on each pop.
- REQ-019 A read at a posedge with state==READY && empty SHALL leave the FIFO unchanged and increment underrun_cnt by 1.
- REQ-020 The state machine SHALL have two states: READY and GAP.
- REQ-021 When a pop occurs and MIN_GAP>0, the state SHALL move READY->GAP and the gap counter SHALL load MIN_GAP-1.
- REQ-022 In GAP, the counter SHALL decrement each cycle; the state SHALL return to READY in the cycle after the counter reads 0.
- REQ-023 When MIN_GAP==0, the state SHALL stay in READY.
- REQ-024 In GAP, a read SHALL return EMPTY_CH, SHALL NOT pop, and SHALL NOT count as an underrun.
- REQ-025 On a simultaneous push and pop with the FIFO non-empty, both SHALL complete and fifo_count SHALL be unchanged.
- REQ-026 On a simultaneous push and read with the FIFO empty, the read SHALL return EMPTY_CH and count as an underrun; the pushed character SHALL be served no earlier than the next cycle.
- REQ-027 On a push attempt while full, the push SHALL be ignored; a pop in the same cycle does not make room visible until the next cycle.
- REQ-028 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
- REQ-029 full/empty SHALL be derived from fifo_count.
- REQ-030 served_cnt and underrun_cnt SHALL wrap modulo 2^32 silently.

Reset
- REQ-031 On reset assertion, all of the following SHALL clear asynchronously, including mid-GAP or mid-transfer:
  - pointers and fifo_count to 0;
  - state to READY and gap counter to 0;
  - served_cnt and underrun_cnt to 0.
- REQ-032 During reset, host_ready SHALL be 1 and io_uart_in_ch SHALL be EMPTY_CH.
- REQ-033 FIFO storage SHALL need no reset, and its contents SHALL never be visible while the FIFO is empty.

Structure
- REQ-034 The state enum (READY, GAP) and the EMPTY_CH default SHALL reside in shared package uart_sim_pkg, which a future uart_out_monitor also uses.
- REQ-035 Storage SHALL be one sub-module, sync_fifo: show-ahead, with DEPTH and WIDTH=8 parameters and push/pop/full/empty/count ports.
- REQ-036 The responder FSM and counters SHALL reside in uart_in_responder.

Verification
- REQ-037 Read with the FIFO empty after reset, 3 cycles of io_uart_in_valid -> io_uart_in_ch=8'hff each cycle, underrun_cnt=3, served_cnt=0.
- REQ-038 Push 'A','B','C', then read on 3 consecutive cycles with MIN_GAP=0 -> io_uart_in_ch=8'h41, 8'h42, 8'h43; served_cnt=3; fifo_count=0.
- REQ-039 Push 16 characters with DEPTH=16 -> host_ready=0 and a 17th push is ignored; push and read in the same cycle -> count stays 15; 20 further push/pop cycles -> order is preserved across pointer wrap.
- REQ-040 MIN_GAP=2, FIFO holds 'x','y', read held high -> 'x' is served, the next 2 cycles return 8'hff with underrun_cnt unchanged, then 'y' is served.
- REQ-041 Empty FIFO, push 'z' and read in the same cycle -> that cycle returns 8'hff with underrun_cnt=1; the next read returns 8'h7a.
- REQ-042 Assert reset asynchronously mid-GAP with fifo_count=5 -> fifo_count, served_cnt and underrun_cnt clear immediately, io_uart_in_ch=8'hff, and the state is READY after release.
